sm_clk_gen: RTL

- Next-generation programmable clock generator for the schoolMIPS core clock.
- Produces a divided core clock `clkOut` and a one-cycle `tick` strobe from the board clock.
- Adds features the plain divider lacks: glitch-free divisor change at period boundaries, divisor clamping, hold, bypass, and a single-step mode driven by a synchronised push-button.
- Sits between the board clock/switch inputs and the CPU clock net in the hardware top level.

---
 rtl/sm_clk_gen_if.sv | 24 ++
 rtl/sm_clk_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sm_clk_gen_if.sv
// Control/status bundle of the programmable core clock generator.
// The master drives the controls and the slave (the generator) drives the status.
interface sm_clk_gen_if #(
   parameter int DIV_W = 5
);
   logic             enable;
   logic [1:0]       mode;
   logic [DIV_W-1:0] devide;
   logic             step;
   logic             clkOut;
   logic             tick;
   logic             busy;
   logic [DIV_W-1:0] devideCur;

   modport master (
      output enable, mode, devide, step,
      input  clkOut, tick, busy, devideCur
   );

   modport slave (
      input  enable, mode, devide, step,
      output clkOut, tick, busy, devideCur
   );
endinterface

// File: rtl/sm_clk_gen.sv
// Programmable core clock generator for schoolMIPS.
// Half-period is 2^devideCur board cycles. Supported modes are free-run,
// single-step, bypass and hold. Divisor and mode changes are only taken at
// period boundaries, so the current half-period is never cut short.
module sm_clk_gen #(
   parameter int WIDTH       = 32,
   parameter int DIV_W       = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   sm_clk_gen_if.slave bus
);
   typedef enum logic [1:0] {
      MODE_RUN  = 2'd0,
      MODE_STEP = 2'd1,
      MODE_BYP  = 2'd2,
      MODE_HOLD = 2'd3
   } mode_t;

   localparam logic [31:0]      MAX_D = 32'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_step_hist;
   logic [WIDTH-1:0]       r_cnt;
   logic                   r_clk_out;
   logic                   r_tick;
   logic                   r_busy;
   logic [DIV_W-1:0]       r_dev_cur;
   mode_t                  r_mode_cur;

   logic [WIDTH-1:0]       w_cnt_next;
   logic                   w_clk_next;
   logic                   w_tick_next;
   logic                   w_busy_next;
   logic [DIV_W-1:0]       w_dev_next;
   mode_t                  w_mode_next;

   logic [DIV_W-1:0]       w_dev_eff;
   logic [WIDTH-1:0]       w_half_m1;
   logic                   w_terminal;
   logic                   w_boundary;
   logic                   w_step_pulse;
   mode_t                  w_mode_in;

   // The exponent is clamped so the half-period counter can always reach terminal.
   assign w_dev_eff    = (32'(bus.devide) > MAX_D) ? MAX_D[DIV_W-1:0] : bus.devide;
   assign w_half_m1    = (ONE << r_dev_cur) - ONE;
   assign w_terminal   = (r_cnt == w_half_m1);
   assign w_step_pulse = r_sync[SYNC_STAGES-1] & ~r_step_hist;
   assign w_mode_in    = mode_t'(bus.mode);

   // Bypass and hold sit permanently at a boundary so they can always be left.
   assign w_boundary = ((r_mode_cur == MODE_RUN) && w_terminal && !r_clk_out) ||
                       ((r_mode_cur == MODE_STEP) && !r_busy) ||
                       (r_mode_cur == MODE_BYP) ||
                       (r_mode_cur == MODE_HOLD);

   // Push-button synchroniser plus the history flop used for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync      <= '0;
         r_step_hist <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.step};
         r_step_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   // State register of the generator.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
         r_busy     <= 1'b0;
         r_dev_cur  <= '0;
         r_mode_cur <= MODE_RUN;
      end else begin
         r_cnt      <= w_cnt_next;
         r_clk_out  <= w_clk_next;
         r_tick     <= w_tick_next;
         r_busy     <= w_busy_next;
         r_dev_cur  <= w_dev_next;
         r_mode_cur <= w_mode_next;
      end
   end

   // Next-state logic: a mode change at a boundary parks the new mode in its
   // idle state, otherwise the current mode advances.
   always_comb begin
      w_cnt_next  = r_cnt;
      w_clk_next  = r_clk_out;
      w_tick_next = 1'b0;
      w_busy_next = r_busy;
      w_dev_next  = r_dev_cur;
      w_mode_next = r_mode_cur;
      if (bus.enable) begin
         if (w_boundary && (w_mode_in != r_mode_cur)) begin
            w_mode_next = w_mode_in;
            w_dev_next  = w_dev_eff;
            w_cnt_next  = '0;
            w_clk_next  = 1'b0;
            w_busy_next = 1'b0;
         end else begin
            // Hold keeps the divisor it entered with.
            if (w_boundary && (r_mode_cur != MODE_HOLD)) begin
               w_dev_next = w_dev_eff;
            end
            case (r_mode_cur)
               MODE_RUN: begin
                  if (w_terminal) begin
                     w_cnt_next  = '0;
                     w_clk_next  = ~r_clk_out;
                     w_tick_next = ~r_clk_out;
                  end else begin
                     w_cnt_next = r_cnt + ONE;
                  end
               end
               MODE_STEP: begin
                  if (r_busy) begin
                     if (w_terminal) begin
                        w_cnt_next  = '0;
                        w_clk_next  = 1'b0;
                        w_busy_next = 1'b0;
                     end else begin
                        w_cnt_next = r_cnt + ONE;
                     end
                  end else if (w_step_pulse) begin
                     w_cnt_next  = '0;
                     w_clk_next  = 1'b1;
                     w_tick_next = 1'b1;
                     w_busy_next = 1'b1;
                  end
               end
               MODE_BYP: begin
                  w_cnt_next  = '0;
                  w_clk_next  = 1'b0;
                  w_tick_next = 1'b1;
               end
               MODE_HOLD: begin
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign bus.clkOut    = r_clk_out;
   assign bus.tick      = r_tick;
   assign bus.busy      = r_busy;
   assign bus.devideCur = r_dev_cur;
endmodule
